// File: rtl/gpg3_spi_pkg.sv
// gpg3_spi_pkg -- shared definitions for the GoPiGo3 SPI motor link.
// Used by the bot-side command receiver and the FPGA master controller,
// so both ends agree on the address, the opcode, the port codes and the
// reply byte shifted out during the first byte of a frame.
package gpg3_spi_pkg;

  localparam logic [7:0] GPG_ADDR          = 8'h08;
  localparam logic [7:0] MSG_SET_MOTOR_DPS = 8'h0E;
  localparam logic [1:0] PORT_LEFT         = 2'd1;
  localparam logic [1:0] PORT_RIGHT        = 2'd2;
  localparam logic [1:0] PORT_BOTH         = 2'd3;
  localparam logic [7:0] MISO_IDLE_BYTE    = 8'hA5;

  // Parser state, one-hot so the state register can drive the LEDs directly.
  typedef enum logic [7:0] {
    S_IDLE   = 8'h01,
    S_ADDR   = 8'h02,
    S_CMD    = 8'h04,
    S_PORT   = 8'h08,
    S_DHI    = 8'h10,
    S_DLO    = 8'h20,
    S_TAIL   = 8'h40,
    S_IGNORE = 8'h80
  } parser_state_t;

  // A port byte is usable only when it selects left, right or both motors.
  function automatic logic port_valid(input logic [7:0] b);
    return (b[7:2] == 6'd0) && (b[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// spi_slave_byte -- SPI mode-0 slave byte engine, oversampled in clk domain.
// Synchronizes sck/ssbar/mosi, detects SCK edges, shifts in MOSI on SCK rise
// and shifts out the reply on SCK fall. The reply for each byte is the byte
// received just before it; the first byte of a frame replies MISO_IDLE_BYTE.
// Ports:
//   clk, rst          system clock, async active-high reset
//   sck, ssbar, mosi  raw SPI pins from the master
//   miso              reply bit, MSB first
//   byte_done         one-clk pulse when rx_byte holds a fresh byte
//   rx_byte           last complete received byte
//   ss_active         synchronized slave-select, high while selected
module spi_slave_byte
  import gpg3_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ssbar,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       ss_active
);

  logic       sck_s1, sck_s2, sck_d;
  logic       ss_s1, ss_s2, ss_d;
  logic       mosi_s1, mosi_s2;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [7:0] rx_next;

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign ss_rise  = ss_s2 & ~ss_d;
  assign ss_fall  = ~ss_s2 & ss_d;
  assign rx_next  = {rx_shift[6:0], mosi_s2};
  assign miso     = tx_shift[7];

  // NOTE: every register here is assigned with <= so all stages of the
  // synchronizer chain sample the previous clock's values, not each other's
  // freshly updated ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1    <= 1'b0;
      sck_s2    <= 1'b0;
      sck_d     <= 1'b0;
      // SSBar chain resets to the deselected level so leaving reset is not
      // mistaken for the start of a frame.
      ss_s1     <= 1'b1;
      ss_s2     <= 1'b1;
      ss_d      <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      rx_byte   <= 8'h00;
      tx_shift  <= 8'h00;
      byte_done <= 1'b0;
      ss_active <= 1'b0;
    end else begin
      sck_s1    <= sck;
      sck_s2    <= sck_s1;
      sck_d     <= sck_s2;
      ss_s1     <= ssbar;
      ss_s2     <= ss_s1;
      ss_d      <= ss_s2;
      mosi_s1   <= mosi;
      mosi_s2   <= mosi_s1;
      byte_done <= 1'b0;
      ss_active <= ~ss_s2;

      if (ss_rise) begin
        // Deselect beats a coincident 8th SCK rise: the byte is dropped.
        bit_cnt  <= 3'd0;
        tx_shift <= 8'h00;
      end else if (ss_fall) begin
        bit_cnt  <= 3'd0;
        tx_shift <= MISO_IDLE_BYTE;
      end else if (!ss_s2) begin
        if (sck_rise) begin
          rx_shift <= rx_next;
          if (bit_cnt == 3'd7) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b1;
            rx_byte   <= rx_next;
            // Echo: the byte just received becomes the next reply, with its
            // MSB on the wire before the next SCK rise.
            tx_shift  <= rx_next;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          // The fall after the 8th rise must not shift: the freshly loaded
          // reply MSB is already presented.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_motor_cmd_rx.sv
// spi_motor_cmd_rx -- GoPiGo3 SET_MOTOR_DPS frame decoder (SPI slave side).
// Parses address, command, port, dps_hi, dps_lo and updates the selected
// motor setpoints. Bytes after dps_lo, and all bytes of a rejected frame,
// are discarded until the master deselects.
// Ports:
//   clk, rst              12 MHz system clock, async active-high reset
//   sck, ssbar, mosi      SPI pins from the master (mode 0)
//   miso                  reply data (echo of the previous byte)
//   dps_left, dps_right   raw 16-bit motor setpoints
//   cmd_valid             one-clk pulse when setpoints are written
//   frame_err             one-clk pulse on bad command or bad port
//   state_leds            one-hot parser state
module spi_motor_cmd_rx
  import gpg3_spi_pkg::*;
#(
  parameter logic [7:0] ADDR    = GPG_ADDR,
  parameter logic [7:0] CMD_DPS = MSG_SET_MOTOR_DPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ssbar,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] dps_left,
  output logic [15:0] dps_right,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  state_leds
);

  logic          byte_done;
  logic [7:0]    rx_byte;
  logic          ss_active;
  parser_state_t state;
  logic [1:0]    port_q;
  logic [7:0]    dhi_q;

  spi_slave_byte u_byte (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ssbar     (ssbar),
    .mosi      (mosi),
    .miso      (miso),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .ss_active (ss_active)
  );

  assign state_leds = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      port_q    <= 2'd0;
      dhi_q     <= 8'h00;
      dps_left  <= 16'h0000;
      dps_right <= 16'h0000;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (!ss_active) begin
        // Deselect from any state ends the frame; nothing partial is kept.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: state <= S_ADDR;
          S_ADDR: if (byte_done) begin
            // Other slaves may share the bus, so a foreign address is silent.
            state <= (rx_byte == ADDR) ? S_CMD : S_IGNORE;
          end
          S_CMD: if (byte_done) begin
            if (rx_byte == CMD_DPS) begin
              state <= S_PORT;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IGNORE;
            end
          end
          S_PORT: if (byte_done) begin
            if (port_valid(rx_byte)) begin
              port_q <= rx_byte[1:0];
              state  <= S_DHI;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IGNORE;
            end
          end
          S_DHI: if (byte_done) begin
            dhi_q <= rx_byte;
            state <= S_DLO;
          end
          S_DLO: if (byte_done) begin
            if (port_q[0]) dps_left  <= {dhi_q, rx_byte};
            if (port_q[1]) dps_right <= {dhi_q, rx_byte};
            cmd_valid <= 1'b1;
            state     <= S_TAIL;
          end
          S_TAIL, S_IGNORE: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_motor_cmd_rx.sv
`timescale 1ns/1ps
module tb_spi_motor_cmd_rx;

  logic        clk = 1'b0;
  logic        rst, sck, ssbar, mosi;
  logic        miso;
  logic [15:0] dps_left, dps_right;
  logic        cmd_valid, frame_err;
  logic [7:0]  state_leds;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;
  int half     = 12;
  int cv_cnt   = 0;
  int fe_cnt   = 0;
  bit chk_en   = 1'b0;

  // Reference model: current setpoints and the values expected if the
  // frame in flight completes.
  logic [15:0] m_left = 16'h0, m_right = 16'h0;
  logic [15:0] nxt_left = 16'h0, nxt_right = 16'h0;

  logic [7:0] fb  [0:11];
  logic [7:0] rep [0:11];

  spi_motor_cmd_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ssbar      (ssbar),
    .mosi       (mosi),
    .miso       (miso),
    .dps_left   (dps_left),
    .dps_right  (dps_right),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err),
    .state_leds (state_leds)
  );

  always #42 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data set while SCK low, both sides sample on the rise.
  task automatic spi_xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      wait_clk(half);
      sck = 1'b1;
      last_rise_cyc = cyc;
      r[i] = miso;
      wait_clk(half);
      sck = 1'b0;
    end
  endtask

  // Sends nbits of b and deselects while SCK is high on the last bit.
  // With simul set the deselect coincides with that last rise.
  task automatic send_partial(input logic [7:0] b, input int nbits, input bit simul);
    logic [7:0] dummy;
    for (int i = 0; i < nbits - 1; i++) begin
      mosi = b[7-i];
      wait_clk(half);
      sck = 1'b1;
      last_rise_cyc = cyc;
      dummy[0] = miso;
      wait_clk(half);
      sck = 1'b0;
    end
    mosi = b[8-nbits];
    wait_clk(half);
    sck = 1'b1;
    last_rise_cyc = cyc;
    if (simul) ssbar = 1'b1;
    wait_clk(half);
    ssbar = 1'b1;
    wait_clk(2);
    sck = 1'b0;
  endtask

  // Frame rules: wrong address is silent; wrong command or port gives one
  // error; five good bytes write the ports selected by the port byte.
  task automatic model_frame(input int n_full, output int e_cv, output int e_fe);
    e_cv = 0;
    e_fe = 0;
    nxt_left  = m_left;
    nxt_right = m_right;
    if (n_full >= 2 && fb[0] == 8'h08) begin
      if (fb[1] != 8'h0E) e_fe = 1;
      else if (n_full >= 3 && !(fb[2] >= 8'd1 && fb[2] <= 8'd3)) e_fe = 1;
      else if (n_full >= 5) begin
        e_cv = 1;
        if (fb[2] == 8'd1 || fb[2] == 8'd3) nxt_left  = {fb[3], fb[4]};
        if (fb[2] == 8'd2 || fb[2] == 8'd3) nxt_right = {fb[3], fb[4]};
      end
    end
  endtask

  task automatic do_frame(input int n_full, input int part_bits, input bit simul);
    int e_cv, e_fe;
    logic [7:0] exp_rep;
    model_frame(n_full, e_cv, e_fe);
    chk_en = 1'b0;
    cv_cnt = 0;
    fe_cnt = 0;
    ssbar = 1'b0;
    wait_clk(half);
    for (int k = 0; k < n_full; k++) begin
      spi_xfer(fb[k], rep[k]);
      exp_rep = (k == 0) ? 8'hA5 : fb[k-1];
      check("miso_byte", 32'(rep[k]), 32'(exp_rep));
    end
    if (part_bits > 0) send_partial(fb[n_full], part_bits, simul);
    else ssbar = 1'b1;
    wait_clk(6);
    check("cmd_valid_count", cv_cnt, e_cv);
    check("frame_err_count", fe_cnt, e_fe);
    m_left  = nxt_left;
    m_right = nxt_right;
    chk_en  = 1'b1;
    wait_clk($urandom_range(1, 4));
  endtask

  // Pulse monitor and idle-time comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        cv_cnt++;
        check("cmd_valid_latency", cyc - last_rise_cyc, 4);
        check("dps_left_at_valid", 32'(dps_left), 32'(nxt_left));
        check("dps_right_at_valid", 32'(dps_right), 32'(nxt_right));
      end
      if (frame_err) begin
        fe_cnt++;
        check("frame_err_latency", cyc - last_rise_cyc, 4);
      end
      if (chk_en) begin
        check("idle_dps_left", 32'(dps_left), 32'(m_left));
        check("idle_dps_right", 32'(dps_right), 32'(m_right));
        check("idle_pulses", {30'd0, cmd_valid, frame_err}, 32'd0);
        check("idle_state", 32'(state_leds), 32'h01);
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_left"}, 32'(dps_left), 32'd0);
    check({tag, "_right"}, 32'(dps_right), 32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_leds"}, 32'(state_leds), 32'h01);
  endtask

  task automatic load(input logic [7:0] b0, b1, b2, b3, b4);
    for (int i = 0; i < 12; i++) fb[i] = 8'h00;
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
  endtask

  initial begin
    logic [7:0] f1_rep [0:6];
    logic [7:0] dummy;
    f1_rep = '{8'hA5, 8'h08, 8'h0E, 8'h03, 8'h03, 8'hE8, 8'h00};
    rst = 1'b1; sck = 1'b0; ssbar = 1'b1; mosi = 1'b0;
    wait_clk(4);
    check_reset_vals("reset");
    rst = 1'b0;
    wait_clk(4);
    chk_en = 1'b1;
    wait_clk(4);

    // Both motors to 0x03E8 at 500 kHz, with two pad bytes.
    half = 12;
    load(8'h08, 8'h0E, 8'h03, 8'h03, 8'hE8);
    do_frame(7, 0, 1'b0);
    check("f1_left", 32'(dps_left), 32'h03E8);
    check("f1_right", 32'(dps_right), 32'h03E8);
    check("f1_cv", cv_cnt, 1);
    check("f1_fe", fe_cnt, 0);
    for (int k = 0; k < 7; k++) check("f1_miso_literal", 32'(rep[k]), 32'(f1_rep[k]));

    // Left only.
    half = $urandom_range(6, 10);
    load(8'h08, 8'h0E, 8'h01, 8'h01, 8'hF4);
    do_frame(5, 0, 1'b0);
    check("f2_left", 32'(dps_left), 32'h01F4);
    check("f2_right", 32'(dps_right), 32'h03E8);

    // Foreign address: silent.
    load(8'h09, 8'h0E, 8'h03, 8'h00, 8'h10);
    do_frame(5, 0, 1'b0);
    check("f3_fe", fe_cnt, 0);
    check("f3_left", 32'(dps_left), 32'h01F4);

    // Bad command, then bad port.
    load(8'h08, 8'h06, 8'h03, 8'h00, 8'h10);
    do_frame(5, 0, 1'b0);
    check("f4_fe", fe_cnt, 1);
    load(8'h08, 8'h0E, 8'h00, 8'h11, 8'h22);
    do_frame(5, 0, 1'b0);
    check("f5_fe", fe_cnt, 1);
    check("f5_right", 32'(dps_right), 32'h03E8);

    // Aborts after 3 bytes and mid-bit of byte 4, then right to 0x0064.
    load(8'h08, 8'h0E, 8'h02, 8'h55, 8'h66);
    do_frame(3, 0, 1'b0);
    do_frame(3, 4, 1'b0);
    load(8'h08, 8'h0E, 8'h02, 8'h00, 8'h64);
    do_frame(5, 0, 1'b0);
    check("f6_right", 32'(dps_right), 32'h0064);
    check("f6_left", 32'(dps_left), 32'h01F4);

    // Deselect coincident with the last rise of dps_lo: byte dropped.
    load(8'h08, 8'h0E, 8'h03, 8'h12, 8'h34);
    do_frame(4, 8, 1'b1);
    check("simul_right", 32'(dps_right), 32'h0064);

    // Reset pulsed while the parser waits for dps_hi.
    chk_en = 1'b0; cv_cnt = 0; fe_cnt = 0;
    load(8'h08, 8'h0E, 8'h03, 8'h77, 8'h88);
    ssbar = 1'b0;
    wait_clk(half);
    for (int k = 0; k < 3; k++) spi_xfer(fb[k], rep[k]);
    spi_xfer_bit: begin
      mosi = 1'b1; wait_clk(half); sck = 1'b1; wait_clk(half); sck = 1'b0;
    end
    wait_clk(2);
    rst = 1'b1;
    wait_clk(3);
    check_reset_vals("midrst");
    rst = 1'b0;
    m_left = 16'h0; m_right = 16'h0;
    wait_clk(10);
    ssbar = 1'b1;
    wait_clk(6);
    check("midrst_cv", cv_cnt, 0);
    load(8'h08, 8'h0E, 8'h03, 8'hAB, 8'hCD);
    do_frame(5, 0, 1'b0);
    check("post_rst_left", 32'(dps_left), 32'hABCD);
    check("post_rst_right", 32'(dps_right), 32'hABCD);
    dummy = 8'h00;

    // Randomized frames against the model.
    for (int f = 0; f < 25; f++) begin
      int nf, pb;
      half = $urandom_range(6, 10);
      load(($urandom_range(0, 4) != 0) ? 8'h08 : 8'($urandom),
           ($urandom_range(0, 4) != 0) ? 8'h0E : 8'($urandom),
           ($urandom_range(0, 5) != 0) ? 8'($urandom_range(0, 4)) : 8'($urandom),
           8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) != 0) nf = $urandom_range(5, 7);
      else nf = $urandom_range(0, 4);
      pb = (nf < 7 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
      do_frame(nf, pb, pb == 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
